// File: rtl/seven_segment_reader.sv
// Decodes a stream of active-low 7-segment patterns back into hex nibbles and
// packs NUM_DIGITS of them (first digit in the top nibble) into one handshaked word.
module seven_segment_reader #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [6:0]              seg_in,
  input  logic                    seg_valid,
  input  logic                    seg_first,
  output logic                    seg_ready,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    value_valid,
  input  logic                    value_ready,
  output logic                    value_err,
  output logic [3:0]              digit_cnt
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [3:0] LastCnt = 4'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [3:0]     nib;
  logic           seg_bad;

  // Unknown patterns (blank included) decode to 0 and poison the frame.
  always_comb begin
    nib     = 4'h0;
    seg_bad = 1'b0;
    case (seg_in)
      7'h40:   nib = 4'h0;
      7'h79:   nib = 4'h1;
      7'h24:   nib = 4'h2;
      7'h30:   nib = 4'h3;
      7'h19:   nib = 4'h4;
      7'h12:   nib = 4'h5;
      7'h02:   nib = 4'h6;
      7'h78:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h10:   nib = 4'h9;
      7'h08:   nib = 4'hA;
      7'h03:   nib = 4'hB;
      7'h27:   nib = 4'hC;
      7'h21:   nib = 4'hD;
      7'h06:   nib = 4'hE;
      7'h0E:   nib = 4'hF;
      default: seg_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: state_d = COLLECT;
      COLLECT: begin
        if (seg_valid) begin
          // A first-digit marker restarts the frame regardless of progress.
          if (seg_first) begin
            shift_d = W'(nib);
            cnt_d   = 4'd1;
            err_d   = seg_bad;
          end else begin
            shift_d = (shift_q << 4) | W'(nib);
            cnt_d   = cnt_q + 4'd1;
            err_d   = err_q | seg_bad;
          end
          if (cnt_d == LastCnt) state_d = HOLD;
        end
      end
      HOLD: begin
        if (value_ready) begin
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign seg_ready   = (state_q == COLLECT);
  assign value_valid = (state_q == HOLD);
  assign value_out   = shift_q;
  assign value_err   = err_q;
  assign digit_cnt   = cnt_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: a 4-digit instance for framing and
// handshake behaviour, plus a 1-digit instance for the full decode sweep.
module tb_seven_segment_reader;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic        seg_first;
  logic        seg_ready;
  logic [15:0] value_out;
  logic        value_valid;
  logic        value_ready;
  logic        value_err;
  logic [3:0]  digit_cnt;

  logic [6:0]  seg1_in;
  logic        seg1_valid;
  logic        seg1_first;
  logic        seg1_ready;
  logic [3:0]  value1_out;
  logic        value1_valid;
  logic        value1_ready;
  logic        value1_err;
  logic [3:0]  digit1_cnt;

  int vecs = 0;
  int errs = 0;

  localparam logic [6:0] CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };

  always #5 CLOCK_50 = ~CLOCK_50;

  seven_segment_reader #(.NUM_DIGITS(4)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .seg_first  (seg_first),
    .seg_ready  (seg_ready),
    .value_out  (value_out),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .value_err  (value_err),
    .digit_cnt  (digit_cnt)
  );

  seven_segment_reader #(.NUM_DIGITS(1)) dut1 (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .seg_in     (seg1_in),
    .seg_valid  (seg1_valid),
    .seg_first  (seg1_first),
    .seg_ready  (seg1_ready),
    .value_out  (value1_out),
    .value_valid(value1_valid),
    .value_ready(value1_ready),
    .value_err  (value1_err),
    .digit_cnt  (digit1_cnt)
  );

  // Offers one digit from a falling edge and returns 1 time unit after the accepting edge.
  task automatic send_digit(input logic [6:0] s, input logic f);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    seg_in    = s;
    seg_first = f;
    seg_valid = 1'b1;
    while (!seg_ready && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    vecs++;
    if (seg_ready !== 1'b1) begin
      errs++;
      $display("[TB] FAIL seg_ready_wait: seg_ready=%b required 1", seg_ready);
    end
    @(posedge CLOCK_50);
    #1;
    seg_valid = 1'b0;
    seg_first = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [15:0] ev, input logic ee);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    while (!value_valid && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    vecs++;
    if (value_valid !== 1'b1) begin
      errs++;
      $display("[TB] FAIL %s_valid_wait: value_valid=%b required 1", name, value_valid);
    end
    vecs++;
    if (value_out !== ev) begin
      errs++;
      $display("[TB] FAIL %s_value: value_out=%h required %h", name, value_out, ev);
    end
    vecs++;
    if (value_err !== ee) begin
      errs++;
      $display("[TB] FAIL %s_err: value_err=%b required %b", name, value_err, ee);
    end
    value_ready = 1'b1;
    @(posedge CLOCK_50);
    #1;
    value_ready = 1'b0;
    vecs++;
    if (value_valid !== 1'b0 || digit_cnt !== 4'd0) begin
      errs++;
      $display("[TB] FAIL %s_release: value_valid=%b digit_cnt=%0d required 0/0", name, value_valid, digit_cnt);
    end
  endtask

  task automatic test_reset;
    #12;
    vecs++;
    if (seg_ready !== 1'b0 || value_valid !== 1'b0 || value_out !== 16'h0 ||
        value_err !== 1'b0 || digit_cnt !== 4'd0) begin
      errs++;
      $display("[TB] FAIL reset_state: rdy=%b vld=%b out=%h err=%b cnt=%0d required 0/0/0000/0/0",
               seg_ready, value_valid, value_out, value_err, digit_cnt);
    end
    repeat (2) @(posedge CLOCK_50);
    #1;
    vecs++;
    if (seg_ready !== 1'b0 || value_valid !== 1'b0) begin
      errs++;
      $display("[TB] FAIL reset_hold: seg_ready=%b value_valid=%b required 0/0", seg_ready, value_valid);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  task automatic test_basic;
    send_digit(7'h79, 1'b1);
    send_digit(7'h24, 1'b0);
    send_digit(7'h30, 1'b0);
    vecs++;
    if (value_valid !== 1'b0 || digit_cnt !== 4'd3) begin
      errs++;
      $display("[TB] FAIL basic_partial: value_valid=%b digit_cnt=%0d required 0/3", value_valid, digit_cnt);
    end
    send_digit(7'h19, 1'b0);
    vecs++;
    if (value_valid !== 1'b1 || seg_ready !== 1'b0) begin
      errs++;
      $display("[TB] FAIL basic_latency: value_valid=%b seg_ready=%b required 1/0", value_valid, seg_ready);
    end
    get_result("basic", 16'h1234, 1'b0);
  endtask

  task automatic test_hold_backpressure;
    send_digit(7'h08, 1'b1);
    send_digit(7'h03, 1'b0);
    send_digit(7'h27, 1'b0);
    send_digit(7'h0E, 1'b0);
    seg_in    = 7'h40;
    seg_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLOCK_50);
      vecs++;
      if (value_out !== 16'hABCF || value_valid !== 1'b1 || seg_ready !== 1'b0 || digit_cnt !== 4'd4) begin
        errs++;
        $display("[TB] FAIL hold_cycle%0d: out=%h vld=%b rdy=%b cnt=%0d required ABCF/1/0/4",
                 c, value_out, value_valid, seg_ready, digit_cnt);
      end
    end
    seg_valid   = 1'b0;
    value_ready = 1'b1;
    @(posedge CLOCK_50);
    #1;
    value_ready = 1'b0;
    vecs++;
    if (value_valid !== 1'b0 || digit_cnt !== 4'd0 || seg_ready !== 1'b1 || value_err !== 1'b0) begin
      errs++;
      $display("[TB] FAIL hold_release: vld=%b cnt=%0d rdy=%b err=%b required 0/0/1/0",
               value_valid, digit_cnt, seg_ready, value_err);
    end
  endtask

  task automatic test_invalid_code;
    send_digit(7'h40, 1'b1);
    send_digit(7'h7F, 1'b0);
    send_digit(7'h00, 1'b0);
    send_digit(7'h10, 1'b0);
    get_result("invalid", 16'h0089, 1'b1);
    send_digit(7'h40, 1'b1);
    send_digit(7'h40, 1'b0);
    send_digit(7'h40, 1'b0);
    send_digit(7'h40, 1'b0);
    get_result("err_clear", 16'h0000, 1'b0);
  endtask

  task automatic test_resync;
    send_digit(7'h79, 1'b1);
    send_digit(7'h24, 1'b0);
    send_digit(7'h06, 1'b1);
    vecs++;
    if (digit_cnt !== 4'd1) begin
      errs++;
      $display("[TB] FAIL resync_cnt: digit_cnt=%0d required 1", digit_cnt);
    end
    send_digit(7'h02, 1'b0);
    send_digit(7'h00, 1'b0);
    send_digit(7'h10, 1'b0);
    get_result("resync", 16'hE689, 1'b0);
  endtask

  task automatic test_sweep;
    int         good;
    int         n;
    logic [3:0] en;
    logic       ee;
    good = 0;
    for (int p = 0; p < 128; p++) begin
      en = 4'h0;
      ee = 1'b1;
      for (int k = 0; k < 16; k++) begin
        if (CODES[k] == 7'(p)) begin
          en = 4'(k);
          ee = 1'b0;
        end
      end
      @(negedge CLOCK_50);
      seg1_in    = 7'(p);
      seg1_valid = 1'b1;
      n = 0;
      while (!seg1_ready && n < 20) begin
        @(negedge CLOCK_50);
        n++;
      end
      @(posedge CLOCK_50);
      #1;
      seg1_valid = 1'b0;
      @(negedge CLOCK_50);
      vecs++;
      if (value1_valid !== 1'b1 || value1_out !== en || value1_err !== ee) begin
        errs++;
        $display("[TB] FAIL sweep_%h: vld=%b nib=%h err=%b required 1/%h/%b",
                 7'(p), value1_valid, value1_out, value1_err, en, ee);
      end
      if (value1_valid === 1'b1 && value1_err === 1'b0) good++;
      value1_ready = 1'b1;
      @(posedge CLOCK_50);
      #1;
      value1_ready = 1'b0;
    end
    vecs++;
    if (good !== 16) begin
      errs++;
      $display("[TB] FAIL sweep_legal_count: count=%0d required 16", good);
    end
  endtask

  task automatic test_async_reset;
    send_digit(7'h79, 1'b1);
    send_digit(7'h24, 1'b0);
    send_digit(7'h30, 1'b0);
    send_digit(7'h19, 1'b0);
    @(negedge CLOCK_50);
    resetn = 1'b0;
    #1;
    vecs++;
    if (value_valid !== 1'b0 || digit_cnt !== 4'd0 || value_out !== 16'h0) begin
      errs++;
      $display("[TB] FAIL reset_in_hold: vld=%b cnt=%0d out=%h required 0/0/0000",
               value_valid, digit_cnt, value_out);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    send_digit(7'h79, 1'b1);
    send_digit(7'h24, 1'b0);
    resetn = 1'b0;
    #1;
    vecs++;
    if (digit_cnt !== 4'd0 || seg_ready !== 1'b0 || value_valid !== 1'b0) begin
      errs++;
      $display("[TB] FAIL reset_mid_frame: cnt=%0d rdy=%b vld=%b required 0/0/0",
               digit_cnt, seg_ready, value_valid);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    send_digit(7'h19, 1'b0);
    send_digit(7'h12, 1'b0);
    send_digit(7'h02, 1'b0);
    send_digit(7'h78, 1'b0);
    get_result("after_reset", 16'h4567, 1'b0);
  endtask

  initial begin
    resetn       = 1'b0;
    seg_in       = 7'h7F;
    seg_valid    = 1'b0;
    seg_first    = 1'b0;
    value_ready  = 1'b0;
    seg1_in      = 7'h7F;
    seg1_valid   = 1'b0;
    seg1_first   = 1'b0;
    value1_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold_backpressure();
    test_invalid_code();
    test_resync();
    test_sweep();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
